// File: rtl/mac_feeder_pkg.sv
// Shared types and constants for the MAC operand feeder: FSM states, operand width,
// downstream MAC pipeline latency and the buffered operand-pair payload.
package mac_feeder_pkg;

  localparam int unsigned OP_W    = 8;
  localparam int unsigned MAC_LAT = 2;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    STREAM,
    DRAIN,
    DONE
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } op_pair_t;

endpackage

// File: rtl/mac_operand_feeder_if.sv
// Producer-side and MAC-side signals of the operand feeder, bundled with modports.
// FEEDER_STALL_CNT_EN adds the stall_cnt observation output.
interface mac_operand_feeder_if #(
  parameter int unsigned LEN_W = 8
);
  import mac_feeder_pkg::*;

  logic              wr_vld;
  logic [OP_W-1:0]   wr_A;
  logic [OP_W-1:0]   wr_B;
  logic              wr_rdy;
  logic              start;
  logic [LEN_W-1:0]  vec_len;
  logic [OP_W-1:0]   A;
  logic [OP_W-1:0]   B;
  logic              en;
  logic              clr;
  logic              busy;
  logic              done;
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  modport master (
    input  wr_vld, wr_A, wr_B, start, vec_len,
`ifdef FEEDER_STALL_CNT_EN
    output stall_cnt,
`endif
    output wr_rdy, A, B, en, clr, busy, done
  );

  modport slave (
    output wr_vld, wr_A, wr_B, start, vec_len,
`ifdef FEEDER_STALL_CNT_EN
    input  stall_cnt,
`endif
    input  wr_rdy, A, B, en, clr, busy, done
  );

endinterface

// File: rtl/mac_op_fifo.sv
// Synchronous DEPTH x W FIFO with registered full/empty flags. Push and pop in the
// same cycle both succeed even at full or empty (empty case bypasses wr_data to rd_data).
module mac_op_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          full_q;
  logic          empty_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (!full_q || pop);
  assign do_pop  = pop && (!empty_q || push);
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty_q ? wr_data : mem[rd_ptr];
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/mac_operand_feeder.sv
// Feeds buffered operand pairs to a 2-stage gated MAC: clr, vec_len en pulses, pipeline
// drain, then done. Optional FEEDER_STALL_CNT_EN adds a saturating empty-FIFO stall counter.
module mac_operand_feeder
  import mac_feeder_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LEN_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  mac_operand_feeder_if.master bus
);
  localparam int unsigned PAIR_W  = $bits(op_pair_t);
  localparam int unsigned DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  state_e             state_q;
  state_e             state_d;
  logic [LEN_W-1:0]   remaining_q;
  logic [LEN_W-1:0]   remaining_d;
  logic [DRAIN_W-1:0] drain_q;
  logic [DRAIN_W-1:0] drain_d;
  logic [OP_W-1:0]    a_q;
  logic [OP_W-1:0]    a_d;
  logic [OP_W-1:0]    b_q;
  logic [OP_W-1:0]    b_d;
  logic               en_q, en_d;
  logic               clr_q, clr_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  op_pair_t           wr_pair;
  op_pair_t           rd_pair;

  assign wr_pair   = '{a: bus.wr_A, b: bus.wr_B};
  assign fifo_push = bus.wr_vld && !fifo_full;

  mac_op_fifo #(
    .DEPTH (DEPTH),
    .W     (PAIR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (wr_pair),
    .pop     (fifo_pop),
    .rd_data (rd_pair),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // STREAM lingers one cycle at remaining==0 so the last en sees the full MAC_LAT drain
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    drain_d     = '0;
    a_d         = a_q;
    b_d         = b_q;
    en_d        = 1'b0;
    clr_d       = 1'b0;
    done_d      = 1'b0;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = CLR;
          clr_d       = 1'b1;
          remaining_d = bus.vec_len;
        end
      end
      CLR: begin
        state_d = (remaining_q != '0) ? STREAM : DRAIN;
      end
      STREAM: begin
        if (remaining_q == '0) begin
          state_d = DRAIN;
        end else if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          en_d        = 1'b1;
          a_d         = rd_pair.a;
          b_d         = rd_pair.b;
          remaining_d = remaining_q - LEN_W'(1);
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_W'(MAC_LAT - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      drain_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      en_q        <= 1'b0;
      clr_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      drain_q     <= drain_d;
      a_q         <= a_d;
      b_q         <= b_d;
      en_q        <= en_d;
      clr_q       <= clr_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.wr_rdy = !fifo_full;
  assign bus.A      = a_q;
  assign bus.B      = b_q;
  assign bus.en     = en_q;
  assign bus.clr    = clr_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;

`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_q;
  logic [15:0] stall_d;

  // Counts STREAM cycles starved by an empty FIFO while pairs are still owed
  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && bus.start) begin
      stall_d = '0;
    end else if (state_q == STREAM && remaining_q != '0 && fifo_empty &&
                 stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign bus.stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder driving a behavioural 2-stage gated MAC model.
// Build with FEEDER_STALL_CNT_EN to also check the stall counter.
module tb_mac_operand_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  int unsigned prod = 0;
  int unsigned accum = 0;
  bit          pv = 1'b0;
  byte unsigned qa[$];
  byte unsigned qb[$];

  mac_operand_feeder_if #(.LEN_W(8)) bus ();

  mac_operand_feeder #(.DEPTH(8), .LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gated MAC: product register, then accumulator update
  always @(posedge clk) begin
    if (bus.clr) begin
      pv    <= 1'b0;
      accum <= 0;
    end else begin
      pv   <= bus.en;
      prod <= 32'(bus.A) * 32'(bus.B);
      if (pv) accum <= accum + prod;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_pair(input byte unsigned a, input byte unsigned b, output bit ok);
    bus.wr_vld = 1'b1;
    bus.wr_A   = a;
    bus.wr_B   = b;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.wr_rdy) ok = 1'b1;
      @(negedge clk);
      if (ok) break;
    end
    bus.wr_vld = 1'b0;
  endtask

  task automatic run_req(input int len, output int clr_n, output int en_n,
                         output int first_en, output int last_en, output int clr_cyc,
                         output int done_cyc, output int unsigned acc, output bit to);
    clr_n = 0; en_n = 0; first_en = -1; last_en = -1; clr_cyc = -1; done_cyc = -1;
    acc = 0; to = 1'b1;
    qa.delete(); qb.delete();
    bus.start   = 1'b1;
    bus.vec_len = 8'(len);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.clr) begin clr_n++; clr_cyc = int'(cyc); end
      if (bus.en) begin
        en_n++;
        if (first_en < 0) first_en = int'(cyc);
        last_en = int'(cyc);
        qa.push_back(bus.A);
        qb.push_back(bus.B);
      end
      if (bus.done) begin done_cyc = int'(cyc); acc = accum; to = 1'b0; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [20:0] v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    v = {bus.en, bus.clr, bus.done, bus.busy, bus.A, bus.B, bus.wr_rdy};
    n_checks++; if (v !== 21'h1) begin n_fail++; $display("FAIL reset_hold: got %h expected %h", v, 21'h1); end
    rst = 1'b0;
    @(negedge clk);
    v = {bus.en, bus.clr, bus.done, bus.busy, bus.A, bus.B, bus.wr_rdy};
    n_checks++; if (v !== 21'h1) begin n_fail++; $display("FAIL reset_release: got %h expected %h", v, 21'h1); end
  endtask

  task automatic test_basic();
    bit ok, all_ok;
    int cn, en, fe, le, cc, dc;
    int unsigned acc;
    bit to;
    all_ok = 1'b1;
    push_pair(8'd2, 8'd3, ok); all_ok &= ok;
    push_pair(8'd4, 8'd5, ok); all_ok &= ok;
    push_pair(8'd6, 8'd7, ok); all_ok &= ok;
    n_checks++; if (all_ok !== 1'b1) begin n_fail++; $display("FAIL basic_push: got %0d expected 1", all_ok); end
    run_req(3, cn, en, fe, le, cc, dc, acc, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %0d expected 0", to); end
    n_checks++; if (cn !== 1) begin n_fail++; $display("FAIL basic_clr_count: got %0d expected 1", cn); end
    n_checks++; if (en !== 3) begin n_fail++; $display("FAIL basic_en_count: got %0d expected 3", en); end
    n_checks++; if (fe !== cc + 2) begin n_fail++; $display("FAIL basic_first_en: got %0d expected %0d", fe, cc + 2); end
    n_checks++; if (le !== fe + 2) begin n_fail++; $display("FAIL basic_back_to_back: got %0d expected %0d", le, fe + 2); end
    n_checks++; if (dc !== le + 3) begin n_fail++; $display("FAIL basic_done_latency: got %0d expected %0d", dc, le + 3); end
    n_checks++; if ({qa[0], qb[0], qa[1], qb[1], qa[2], qb[2]} !== 48'h020304050607) begin
      n_fail++; $display("FAIL basic_operands: got %h expected %h", {qa[0], qb[0], qa[1], qb[1], qa[2], qb[2]}, 48'h020304050607); end
    n_checks++; if (acc !== 68) begin n_fail++; $display("FAIL basic_accum: got %0d expected 68", acc); end
`ifdef FEEDER_STALL_CNT_EN
    n_checks++; if (bus.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL basic_stall_cnt: got %0d expected 0", bus.stall_cnt); end
`endif
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy: got %0d expected 0", bus.busy); end
  endtask

  task automatic test_stall();
    int cn, en, fe, le, cc, dc;
    int unsigned acc;
    bit to;
    fork
      run_req(4, cn, en, fe, le, cc, dc, acc, to);
      begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          bus.wr_vld = 1'b1; bus.wr_A = 8'd1; bus.wr_B = 8'd1;
          @(negedge clk);
          bus.wr_vld = 1'b0;
          repeat (2) @(negedge clk);
        end
      end
    join
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL stall_timeout: got %0d expected 0", to); end
    n_checks++; if (en !== 4) begin n_fail++; $display("FAIL stall_en_count: got %0d expected 4", en); end
    n_checks++; if (fe !== cc + 3) begin n_fail++; $display("FAIL stall_first_en: got %0d expected %0d", fe, cc + 3); end
    n_checks++; if (le !== cc + 12) begin n_fail++; $display("FAIL stall_last_en: got %0d expected %0d", le, cc + 12); end
    n_checks++; if (dc !== le + 3) begin n_fail++; $display("FAIL stall_done_latency: got %0d expected %0d", dc, le + 3); end
    n_checks++; if (acc !== 4) begin n_fail++; $display("FAIL stall_accum: got %0d expected 4", acc); end
`ifdef FEEDER_STALL_CNT_EN
    n_checks++; if (bus.stall_cnt !== 16'd7) begin n_fail++; $display("FAIL stall_cnt: got %0d expected 7", bus.stall_cnt); end
    repeat (2) @(negedge clk);
    n_checks++; if (bus.stall_cnt !== 16'd7) begin n_fail++; $display("FAIL stall_cnt_hold: got %0d expected 7", bus.stall_cnt); end
`endif
    @(negedge clk);
  endtask

  task automatic test_full();
    bit ok, all_ok, held, got9;
    int cn, en, fe, le, cc, dc;
    int unsigned acc;
    bit to;
    all_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_pair(8'(10 + i), 8'(20 + i), ok);
      all_ok &= ok;
    end
    n_checks++; if (all_ok !== 1'b1) begin n_fail++; $display("FAIL full_push8: got %0d expected 1", all_ok); end
    n_checks++; if (bus.wr_rdy !== 1'b0) begin n_fail++; $display("FAIL full_wr_rdy: got %0d expected 0", bus.wr_rdy); end
    bus.wr_vld = 1'b1; bus.wr_A = 8'd99; bus.wr_B = 8'd99;
    held = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.wr_rdy !== 1'b0) held = 1'b0;
    end
    n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL full_hold_off: got %0d expected 1", held); end
    got9 = 1'b0;
    fork
      run_req(8, cn, en, fe, le, cc, dc, acc, to);
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (bus.wr_rdy) begin
            @(negedge clk);
            got9 = 1'b1;
            break;
          end
        end
        bus.wr_vld = 1'b0;
      end
    join
    n_checks++; if (got9 !== 1'b1) begin n_fail++; $display("FAIL full_ninth_accepted: got %0d expected 1", got9); end
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL full_timeout: got %0d expected 0", to); end
    n_checks++; if (le - fe !== 7 || en !== 8) begin n_fail++; $display("FAIL full_en_run: got span %0d count %0d expected span 7 count 8", le - fe, en); end
    n_checks++; if (acc !== 2580) begin n_fail++; $display("FAIL full_accum: got %0d expected 2580", acc); end
    @(negedge clk);
    run_req(1, cn, en, fe, le, cc, dc, acc, to);
    n_checks++; if (acc !== 9801 || en !== 1) begin n_fail++; $display("FAIL full_leftover: got acc %0d en %0d expected acc 9801 en 1", acc, en); end
    @(negedge clk);
  endtask

  task automatic test_zero_len();
    bit bad;
    int cn, en, fe, le, cc, dc;
    int unsigned acc;
    bit to;
    fork
      run_req(0, cn, en, fe, le, cc, dc, acc, to);
      begin
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.vec_len = 8'd5;
        @(negedge clk);
        bus.start = 1'b0;
      end
    join
    n_checks++; if (to !== 1'b0 || cn !== 1) begin n_fail++; $display("FAIL zero_clr: got to %0d clr %0d expected to 0 clr 1", to, cn); end
    n_checks++; if (en !== 0) begin n_fail++; $display("FAIL zero_en_count: got %0d expected 0", en); end
    n_checks++; if (dc !== cc + 3) begin n_fail++; $display("FAIL zero_done_latency: got %0d expected %0d", dc, cc + 3); end
    n_checks++; if (acc !== 0) begin n_fail++; $display("FAIL zero_accum: got %0d expected 0", acc); end
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.busy || bus.clr || bus.en) bad = 1'b1;
    end
    n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL zero_start_ignored: got %0d expected 0", bad); end
  endtask

  task automatic test_reset_mid();
    bit ok, all_ok;
    int seen;
    logic [20:0] v;
    int cn, en, fe, le, cc, dc;
    int unsigned acc;
    bit to;
    all_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin push_pair(8'd3, 8'd3, ok); all_ok &= ok; end
    bus.start = 1'b1; bus.vec_len = 8'd5;
    @(negedge clk);
    bus.start = 1'b0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.en) seen++;
      if (seen == 2) break;
      @(negedge clk);
    end
    n_checks++; if (seen !== 2 || all_ok !== 1'b1) begin n_fail++; $display("FAIL rstmid_setup: got en %0d push %0d expected en 2 push 1", seen, all_ok); end
    rst = 1'b1;
    #1;
    v = {bus.en, bus.clr, bus.done, bus.busy, bus.A, bus.B, bus.wr_rdy};
    n_checks++; if (v !== 21'h1) begin n_fail++; $display("FAIL rstmid_outputs: got %h expected %h", v, 21'h1); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_pair(8'd255, 8'd255, ok); all_ok = ok;
    push_pair(8'd255, 8'd255, ok); all_ok &= ok;
    run_req(2, cn, en, fe, le, cc, dc, acc, to);
    n_checks++; if ({qa[0], qb[0], qa[1], qb[1]} !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL rstmid_flushed: got %h expected ffffffff", {qa[0], qb[0], qa[1], qb[1]}); end
    n_checks++; if (acc !== 130050 || to !== 1'b0) begin n_fail++; $display("FAIL rstmid_accum: got %0d expected 130050", acc); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok, all_ok;
    int cn, en, fe, le, cc, dc;
    int unsigned acc;
    bit to;
    all_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin push_pair(8'(2 * i + 1), 8'(2 * i + 2), ok); all_ok &= ok; end
    run_req(3, cn, en, fe, le, cc, dc, acc, to);
    n_checks++; if (acc !== 44 || to !== 1'b0 || all_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_first_accum: got %0d expected 44", acc); end
    @(negedge clk);
    run_req(3, cn, en, fe, le, cc, dc, acc, to);
    n_checks++; if ({qa[0], qa[1], qa[2]} !== 24'h07090B) begin n_fail++; $display("FAIL b2b_second_operands: got %h expected 07090b", {qa[0], qa[1], qa[2]}); end
    n_checks++; if (acc !== 278 || to !== 1'b0) begin n_fail++; $display("FAIL b2b_second_accum: got %0d expected 278", acc); end
    @(negedge clk);
  endtask

  initial begin
    bus.wr_vld  = 1'b0;
    bus.wr_A    = 8'd0;
    bus.wr_B    = 8'd0;
    bus.start   = 1'b0;
    bus.vec_len = 8'd0;
    test_reset();
    test_basic();
    test_stall();
    test_full();
    test_zero_len();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
